// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and types for the write-back stage
package wb_pkg;

  // RV64I major opcodes seen by write-back
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;

  // Load width/sign selectors (func3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Idle write-back: addi x0 opcode aimed at x0, harmless to the register file
  localparam logic [6:0] NOP_OPCODE = OP_IMM;
  localparam logic [4:0] RD_ZERO    = 5'd0;

  typedef enum logic {IDLE, LOAD_WAIT} wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - extracts and extends load data from a doubleword
module wb_load_align
  import wb_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [2:0]  offset,
  input  logic [63:0] rdata,
  output logic [63:0] result,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  // Lane selection; half/word indices drop low offset bits so they stay in range
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = rdata[{offset[2:1], 4'b0000} +: 16];
    word_sel = rdata[{offset[2], 5'b00000} +: 32];
  end

  // Width/sign extension; func3 111 falls through to the doubleword case
  always_comb begin
    case (func3)
      F3_LB:   result = {{56{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {56'd0, byte_sel};
      F3_LH:   result = {{48{half_sel[15]}}, half_sel};
      F3_LHU:  result = {48'd0, half_sel};
      F3_LW:   result = {{32{word_sel[31]}}, word_sel};
      F3_LWU:  result = {32'd0, word_sel};
      default: result = rdata;
    endcase
  end

  // Natural-alignment check per access width
  always_comb begin
    case (func3)
      F3_LH, F3_LHU: misaligned = offset[0];
      F3_LW, F3_LWU: misaligned = |offset[1:0];
      F3_LD, 3'b111: misaligned = |offset;
      default:       misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV64I write-back stage with variable-latency load wait
module wb_stage #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int XLEN         = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic [6:0]      mem_opcode,
  input  logic [4:0]      mem_rd,
  input  logic [2:0]      mem_func3,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_pc_plus4,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic [XLEN-1:0] wdata,
  output logic [4:0]      wrd,
  output logic [6:0]      wopcode,
  output logic            misalign,
  output logic            bus_err
);
  import wb_pkg::*;

  localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_e state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [4:0]       cap_rd;
  logic [2:0]       cap_func3;
  logic [2:0]       cap_off;

  logic             is_load;
  logic [2:0]       align_func3;
  logic [2:0]       align_off;
  logic [XLEN-1:0]  ld_result;
  logic             ld_misaligned;
  logic             timed_out;

  logic [XLEN-1:0]  wdata_nxt;
  logic [4:0]       wrd_nxt;
  logic [6:0]       wopcode_nxt;
  logic             misalign_nxt;
  logic             bus_err_nxt;

  // The aligner sees live inputs in IDLE and the captured load while waiting
  always_comb begin
    is_load     = (mem_opcode == LOAD);
    align_func3 = (state == LOAD_WAIT) ? cap_func3 : mem_func3;
    align_off   = (state == LOAD_WAIT) ? cap_off : mem_alu_result[2:0];
    timed_out   = (cnt == TMO_LAST);
  end

  wb_load_align u_align (
    .func3      (align_func3),
    .offset     (align_off),
    .rdata      (dmem_rdata),
    .result     (ld_result),
    .misaligned (ld_misaligned)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: only an aligned load without same-cycle data enters the wait
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_valid && is_load && !ld_misaligned && !dmem_rvalid)
          state_nxt = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if (dmem_rvalid || timed_out)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: stall plus the values registered at the next edge (NOP by default)
  always_comb begin
    stall        = 1'b0;
    wdata_nxt    = '0;
    wrd_nxt      = RD_ZERO;
    wopcode_nxt  = NOP_OPCODE;
    misalign_nxt = 1'b0;
    bus_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          if (is_load) begin
            if (ld_misaligned) begin
              misalign_nxt = 1'b1;
            end else if (dmem_rvalid) begin
              wdata_nxt   = ld_result;
              wrd_nxt     = mem_rd;
              wopcode_nxt = LOAD;
            end else begin
              stall = 1'b1;
            end
          end else begin
            wopcode_nxt = mem_opcode;
            wrd_nxt     = mem_rd;
            case (mem_opcode)
              JAL, JALR:                  wdata_nxt = mem_pc_plus4;
              OP_32, OP_IMM_32:           wdata_nxt = {{(XLEN-32){mem_alu_result[31]}}, mem_alu_result[31:0]};
              LUI, AUIPC, OP, OP_IMM:     wdata_nxt = mem_alu_result;
              default:                    wrd_nxt   = RD_ZERO;
            endcase
          end
        end
      end
      LOAD_WAIT: begin
        stall = !dmem_rvalid;
        if (dmem_rvalid) begin
          wdata_nxt   = ld_result;
          wrd_nxt     = cap_rd;
          wopcode_nxt = LOAD;
        end else if (timed_out) begin
          bus_err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered write-port outputs, load capture and timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdata     <= '0;
      wrd       <= RD_ZERO;
      wopcode   <= NOP_OPCODE;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      cnt       <= '0;
      cap_rd    <= RD_ZERO;
      cap_func3 <= 3'd0;
      cap_off   <= 3'd0;
    end else begin
      wdata    <= wdata_nxt;
      wrd      <= wrd_nxt;
      wopcode  <= wopcode_nxt;
      misalign <= misalign_nxt;
      bus_err  <= bus_err_nxt;
      if (state == IDLE && state_nxt == LOAD_WAIT) begin
        cap_rd    <= mem_rd;
        cap_func3 <= mem_func3;
        cap_off   <= mem_alu_result[2:0];
        cnt       <= '0;
      end else if (state == LOAD_WAIT && !dmem_rvalid) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

  localparam int T = 16;

  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;
  localparam logic [6:0] C_BRANCH = 7'b1100011;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_JALR   = 7'b1100111;
  localparam logic [6:0] C_LUI    = 7'b0110111;
  localparam logic [6:0] C_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP     = 7'b0110011;
  localparam logic [6:0] C_OPI    = 7'b0010011;
  localparam logic [6:0] C_OP32   = 7'b0111011;
  localparam logic [6:0] C_OPI32  = 7'b0011011;
  localparam logic [6:0] C_NOP    = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [6:0]  mem_opcode = 7'd0;
  logic [4:0]  mem_rd = 5'd0;
  logic [2:0]  mem_func3 = 3'd0;
  logic [63:0] mem_alu_result = 64'd0;
  logic [63:0] mem_pc_plus4 = 64'd0;
  logic        dmem_rvalid = 1'b0;
  logic [63:0] dmem_rdata = 64'd0;
  logic        stall;
  logic [63:0] wdata;
  logic [4:0]  wrd;
  logic [6:0]  wopcode;
  logic        misalign;
  logic        bus_err;

  wb_stage #(.LOAD_TIMEOUT(T), .XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_rd(mem_rd),
    .mem_func3(mem_func3), .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall(stall), .wdata(wdata), .wrd(wrd), .wopcode(wopcode),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [63:0] wdata;
    logic [4:0]  wrd;
    logic [6:0]  wopc;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    string       name;
    logic        valid;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [63:0] alu;
    logic [63:0] pc4;
    logic        rvalid;
    logic [63:0] rdata;
    logic [63:0] e_wdata;
    logic [4:0]  e_wrd;
    logic [6:0]  e_wopc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [63:0] wd, input logic [4:0] rd,
                            input logic [6:0] op, input logic mis, input logic be);
    exp_t e;
    e.cyc = cyc + 1; e.name = name; e.wdata = wd; e.wrd = rd; e.wopc = op; e.mis = mis; e.berr = be;
    sb.push_back(e);
  endtask

  task automatic expect_nop(input string name);
    expect_out(name, 64'd0, 5'd0, C_NOP, 1'b0, 1'b0);
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [63:0] alu, input logic [63:0] pc4, input logic rv, input logic [63:0] rdat);
    mem_valid = v; mem_opcode = opc; mem_rd = rd; mem_func3 = f3;
    mem_alu_result = alu; mem_pc_plus4 = pc4; dmem_rvalid = rv; dmem_rdata = rdat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic v, input logic [6:0] opc, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] pc4,
                              input logic rv, input logic [63:0] rdat, input logic [63:0] ewd,
                              input logic [4:0] erd, input logic [6:0] eop, input logic emis);
    vec_t r;
    r.name = name; r.valid = v; r.opc = opc; r.rd = rd; r.f3 = f3; r.alu = alu; r.pc4 = pc4;
    r.rvalid = rv; r.rdata = rdat; r.e_wdata = ewd; r.e_wrd = erd; r.e_wopc = eop; r.e_mis = emis;
    return r;
  endfunction

  // Scoreboard: compare every expectation due at this cycle, away from the posedge
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check({e.name, ".wdata"},    wdata,    e.wdata);
      check({e.name, ".wrd"},      {59'd0, wrd},     {59'd0, e.wrd});
      check({e.name, ".wopcode"},  {57'd0, wopcode}, {57'd0, e.wopc});
      check({e.name, ".misalign"}, {63'd0, misalign}, {63'd0, e.mis});
      check({e.name, ".bus_err"},  {63'd0, bus_err},  {63'd0, e.berr});
    end
  end

  // Load with a given number of no-data cycles, then one rvalid cycle
  task automatic wait_load(input string name, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [63:0] addr, input logic [63:0] rdat, input int waits,
                           input logic [63:0] ewd);
    for (int i = 0; i < waits; i++) begin
      drive(1'b1, C_LOAD, rd, f3, addr, 64'd0, 1'b0, rdat);
      #1 check({name, ".stall_hi"}, {63'd0, stall}, 64'd1);
      expect_nop({name, ".wait"});
      tick();
    end
    drive(1'b1, C_LOAD, rd, f3, addr, 64'd0, 1'b1, rdat);
    #1 check({name, ".stall_lo"}, {63'd0, stall}, 64'd0);
    expect_out({name, ".ret"}, ewd, rd, C_LOAD, 1'b0, 1'b0);
    tick();
    drive(1'b0, C_OPI, 5'd0, 3'd0, 64'd0, 64'd0, 1'b0, 64'd0);
    expect_nop({name, ".after"});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single-cycle stimulus table: retire next edge, stall never raised
    vecs.push_back(mk("add",      1, C_OP,    5,  3'd0, 64'hFFFF_FFFF_8000_0001, 64'd0, 0, 64'd0, 64'hFFFF_FFFF_8000_0001, 5,  C_OP,    0));
    vecs.push_back(mk("addw",     1, C_OP32,  5,  3'd0, 64'h0000_0000_8000_0001, 64'd0, 0, 64'd0, 64'hFFFF_FFFF_8000_0001, 5,  C_OP32,  0));
    vecs.push_back(mk("addiw",    1, C_OPI32, 7,  3'd0, 64'h1234_5678_7FFF_FFFF, 64'd0, 0, 64'd0, 64'h0000_0000_7FFF_FFFF, 7,  C_OPI32, 0));
    vecs.push_back(mk("jal",      1, C_JAL,   1,  3'd0, 64'h0000_0000_0000_DEAD, 64'h1004, 0, 64'd0, 64'h1004, 1, C_JAL,  0));
    vecs.push_back(mk("jalr",     1, C_JALR,  2,  3'd0, 64'h0000_0000_0000_BEEF, 64'h2008, 0, 64'd0, 64'h2008, 2, C_JALR, 0));
    vecs.push_back(mk("lui",      1, C_LUI,   3,  3'd0, 64'hFFFF_FFFF_ABCD_E000, 64'd0, 0, 64'd0, 64'hFFFF_FFFF_ABCD_E000, 3, C_LUI, 0));
    vecs.push_back(mk("auipc",    1, C_AUIPC, 4,  3'd0, 64'h0000_0000_1000_2000, 64'd0, 0, 64'd0, 64'h0000_0000_1000_2000, 4, C_AUIPC, 0));
    vecs.push_back(mk("addi",     1, C_OPI,   8,  3'd0, 64'h0000_0000_0000_0042, 64'd0, 0, 64'd0, 64'h42, 8, C_OPI, 0));
    vecs.push_back(mk("store",    1, C_STORE, 9,  3'd3, 64'h55, 64'd0, 0, 64'd0, 64'd0, 0, C_STORE,  0));
    vecs.push_back(mk("branch",   1, C_BRANCH,10, 3'd0, 64'h66, 64'd0, 0, 64'd0, 64'd0, 0, C_BRANCH, 0));
    vecs.push_back(mk("unknown",  1, 7'h7F,   11, 3'd0, 64'h77, 64'd0, 0, 64'd0, 64'd0, 0, 7'h7F,    0));
    vecs.push_back(mk("op_rd0",   1, C_OP,    0,  3'd0, 64'h77, 64'd0, 0, 64'd0, 64'h77, 0, C_OP, 0));
    vecs.push_back(mk("ld_zw",    1, C_LOAD,  12, 3'b011, 64'h1000, 64'd0, 1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 12, C_LOAD, 0));
    vecs.push_back(mk("lh_zw",    1, C_LOAD,  13, 3'b001, 64'h1006, 64'd0, 1, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 13, C_LOAD, 0));
    vecs.push_back(mk("lwu_zw",   1, C_LOAD,  14, 3'b110, 64'h1004, 64'd0, 1, 64'h8000_0002_0000_0000, 64'h0000_0000_8000_0002, 14, C_LOAD, 0));
    vecs.push_back(mk("lbu_zw",   1, C_LOAD,  15, 3'b100, 64'h1007, 64'd0, 1, 64'hFE00_0000_0000_0000, 64'h0000_0000_0000_00FE, 15, C_LOAD, 0));
    vecs.push_back(mk("lw_zw",    1, C_LOAD,  16, 3'b010, 64'h1000, 64'd0, 1, 64'h1111_1111_F000_0003, 64'hFFFF_FFFF_F000_0003, 16, C_LOAD, 0));
    vecs.push_back(mk("f3_111",   1, C_LOAD,  17, 3'b111, 64'h1008, 64'd0, 1, 64'hA5A5_0000_0000_5A5A, 64'hA5A5_0000_0000_5A5A, 17, C_LOAD, 0));
    vecs.push_back(mk("lw_mis",   1, C_LOAD,  18, 3'b010, 64'h0002, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, C_NOP, 1));
    vecs.push_back(mk("ld_mis",   1, C_LOAD,  19, 3'b011, 64'h0004, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, C_NOP, 1));
    vecs.push_back(mk("lh_mis",   1, C_LOAD,  20, 3'b101, 64'h0001, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, C_NOP, 1));
    vecs.push_back(mk("idle",     0, C_OP,    21, 3'd0, 64'h99, 64'd0, 0, 64'd0, 64'd0, 0, C_NOP, 0));

    // Reset values while rst is held
    tick();
    tick();
    check("rst.wdata",    wdata, 64'd0);
    check("rst.wrd",      {59'd0, wrd}, 64'd0);
    check("rst.wopcode",  {57'd0, wopcode}, {57'd0, C_NOP});
    check("rst.misalign", {63'd0, misalign}, 64'd0);
    check("rst.bus_err",  {63'd0, bus_err}, 64'd0);
    rst = 1'b0;

    // Idle for five cycles
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, C_OP, 5'd3, 3'd0, 64'h1, 64'h2, 1'b0, 64'd0);
      #1 check("idle.stall", {63'd0, stall}, 64'd0);
      expect_nop("idle");
      tick();
    end

    // Table: back-to-back single-cycle retirements
    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].opc, vecs[i].rd, vecs[i].f3, vecs[i].alu, vecs[i].pc4,
            vecs[i].rvalid, vecs[i].rdata);
      #1 check({vecs[i].name, ".stall"}, {63'd0, stall}, 64'd0);
      expect_out(vecs[i].name, vecs[i].e_wdata, vecs[i].e_wrd, vecs[i].e_wopc, vecs[i].e_mis, 1'b0);
      tick();
    end

    // Variable-latency loads: three stall cycles, then data
    wait_load("lb_wait",  3'b000, 5'd6, 64'h0000_0000_0000_1003, 64'h0000_0000_8000_0000, 3, 64'hFFFF_FFFF_FFFF_FF80);
    wait_load("lbu_wait", 3'b100, 5'd6, 64'h0000_0000_0000_1003, 64'h0000_0000_8000_0000, 3, 64'h0000_0000_0000_0080);
    wait_load("ld_wait1", 3'b011, 5'd9, 64'h0000_0000_0000_2000, 64'hCAFE_F00D_1234_5678, 1, 64'hCAFE_F00D_1234_5678);

    // Timeout: stall for the IDLE cycle plus T wait cycles, then one bus_err pulse
    for (int i = 0; i <= T; i++) begin
      drive(1'b1, C_LOAD, 5'd22, 3'b011, 64'h3000, 64'd0, 1'b0, 64'd0);
      #1 check("tmo.stall_hi", {63'd0, stall}, 64'd1);
      expect_out("tmo", 64'd0, 5'd0, C_NOP, 1'b0, (i == T));
      tick();
    end
    drive(1'b0, C_OPI, 5'd0, 3'd0, 64'd0, 64'd0, 1'b0, 64'd0);
    #1 check("tmo.stall_lo", {63'd0, stall}, 64'd0);
    expect_nop("tmo.after");
    tick();

    // Reset in the middle of a load wait abandons the load
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, C_LOAD, 5'd23, 3'b011, 64'h4000, 64'd0, 1'b0, 64'h1234);
      expect_nop("rstw.wait");
      tick();
    end
    rst = 1'b1;
    mem_valid = 1'b0;
    #1;
    check("rstw.wdata",    wdata, 64'd0);
    check("rstw.wrd",      {59'd0, wrd}, 64'd0);
    check("rstw.wopcode",  {57'd0, wopcode}, {57'd0, C_NOP});
    check("rstw.misalign", {63'd0, misalign}, 64'd0);
    check("rstw.bus_err",  {63'd0, bus_err}, 64'd0);
    check("rstw.stall",    {63'd0, stall}, 64'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, C_OPI, 5'd0, 3'd0, 64'd0, 64'd0, 1'b1, 64'hDEAD_BEEF);
    #1 check("stray.stall", {63'd0, stall}, 64'd0);
    expect_nop("stray");
    tick();
    drive(1'b1, C_OP, 5'd24, 3'd0, 64'h0000_0000_0000_ABCD, 64'd0, 1'b0, 64'd0);
    expect_out("recover", 64'hABCD, 5'd24, C_OP, 1'b0, 1'b0);
    tick();
    drive(1'b0, C_OPI, 5'd0, 3'd0, 64'd0, 64'd0, 1'b0, 64'd0);
    expect_nop("final");
    tick();
    tick();
    tick();

    check("sb.drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
